// File: rtl/change_dispenser_if.sv
// Controller <-> change dispenser signal bundle.
interface change_dispenser_if;
  localparam int unsigned AMT_W = 8;
  localparam int unsigned DEN_N = 3;

  logic             start;
  logic [AMT_W-1:0] change_due;
  logic [DEN_N-1:0] hopper_empty;
  logic [DEN_N-1:0] coin_out;
  logic             busy;
  logic             done;
  logic             error;
  logic [AMT_W-1:0] remaining;
  logic [AMT_W-1:0] dispensed_total;

  modport master (
    output start, change_due, hopper_empty,
    input  coin_out, busy, done, error, remaining, dispensed_total
  );

  modport slave (
    input  start, change_due, hopper_empty,
    output coin_out, busy, done, error, remaining, dispensed_total
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin payout (5,2,1) driving hopper solenoids with timed pulse/gap.
module change_dispenser #(
  parameter int unsigned PULSE_CYCLES = 5000000,
  parameter int unsigned GAP_CYCLES   = 10000000
) (
  input  logic               clk,
  input  logic               rst_n,
  change_dispenser_if.slave  bus
);
  localparam int unsigned AMT_W   = 8;
  localparam int unsigned CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE, SELECT, PULSE, GAP, DONE, ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       coin_q, coin_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [AMT_W-1:0] tot_q, tot_d;

  // State and output registers; reset clears every output immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      coin_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      rem_q   <= '0;
      tot_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      coin_q  <= coin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      rem_q   <= rem_d;
      tot_q   <= tot_d;
    end
  end

  // Next-state and next-output logic; largest non-empty denomination that fits wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    coin_d  = coin_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    rem_d   = rem_q;
    tot_d   = tot_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          rem_d   = bus.change_due;
          tot_d   = '0;
          busy_d  = 1'b1;
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (rem_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else if (rem_q >= AMT_W'(5) && !bus.hopper_empty[2]) begin
          coin_d  = 3'b100;
          rem_d   = rem_q - AMT_W'(5);
          tot_d   = tot_q + AMT_W'(5);
          cnt_d   = CNT_W'(PULSE_CYCLES - 1);
          state_d = PULSE;
        end else if (rem_q >= AMT_W'(2) && !bus.hopper_empty[1]) begin
          coin_d  = 3'b010;
          rem_d   = rem_q - AMT_W'(2);
          tot_d   = tot_q + AMT_W'(2);
          cnt_d   = CNT_W'(PULSE_CYCLES - 1);
          state_d = PULSE;
        end else if (!bus.hopper_empty[0]) begin
          coin_d  = 3'b001;
          rem_d   = rem_q - AMT_W'(1);
          tot_d   = tot_q + AMT_W'(1);
          cnt_d   = CNT_W'(PULSE_CYCLES - 1);
          state_d = PULSE;
        end else begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ERROR;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          coin_d  = '0;
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = SELECT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.coin_out        = coin_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.error           = error_q;
  assign bus.remaining       = rem_q;
  assign bus.dispensed_total = tot_q;
endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with PULSE_CYCLES=3, GAP_CYCLES=2.
module tb_change_dispenser;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  change_dispenser_if bus ();

  change_dispenser #(.PULSE_CYCLES(3), .GAP_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just before the rising coin edge; ends in SELECT after the gap.
  task automatic coin_pulse(input string tag, input logic [2:0] coin,
                            input logic [7:0] rem, input logic [7:0] tot);
    tick();
    chk({tag, "_rise"}, 8'(bus.coin_out), 8'(coin));
    chk({tag, "_rem"}, bus.remaining, rem);
    chk({tag, "_tot"}, bus.dispensed_total, tot);
    chk({tag, "_busy"}, 8'(bus.busy), 8'd1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk({tag, "_hold"}, 8'(bus.coin_out), 8'(coin));
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk({tag, "_gap"}, 8'(bus.coin_out), 8'd0);
    end
  endtask

  task automatic kick(input logic [7:0] amt, input logic [2:0] empty);
    bus.change_due   = amt;
    bus.hopper_empty = empty;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_busy", 8'(bus.busy), 8'd1);
    chk("start_rem", bus.remaining, amt);
    chk("start_coin", 8'(bus.coin_out), 8'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.start        = 1'b0;
    bus.change_due   = 8'd0;
    bus.hopper_empty = 3'b000;
    #12;
    chk("rst_coin", 8'(bus.coin_out), 8'd0);
    chk("rst_busy", 8'(bus.busy), 8'd0);
    chk("rst_done", 8'(bus.done), 8'd0);
    chk("rst_err", 8'(bus.error), 8'd0);
    chk("rst_rem", bus.remaining, 8'd0);
    chk("rst_tot", bus.dispensed_total, 8'd0);
    rst_n = 1'b1;
    tick();

    // 1: 8 -> 5,2,1
    kick(8'd8, 3'b000);
    coin_pulse("t1_c5", 3'b100, 8'd3, 8'd5);
    coin_pulse("t1_c2", 3'b010, 8'd1, 8'd7);
    coin_pulse("t1_c1", 3'b001, 8'd0, 8'd8);
    tick();
    chk("t1_done", 8'(bus.done), 8'd1);
    chk("t1_busy", 8'(bus.busy), 8'd0);
    chk("t1_rem", bus.remaining, 8'd0);
    chk("t1_tot", bus.dispensed_total, 8'd8);
    tick();
    chk("t1_done_clr", 8'(bus.done), 8'd0);

    // 2: zero change
    kick(8'd0, 3'b000);
    chk("t2_done_early", 8'(bus.done), 8'd0);
    tick();
    chk("t2_done", 8'(bus.done), 8'd1);
    chk("t2_busy", 8'(bus.busy), 8'd0);
    chk("t2_coin", 8'(bus.coin_out), 8'd0);
    tick();
    chk("t2_done_clr", 8'(bus.done), 8'd0);

    // 3: 5-hopper empty, 5 -> 2,2,1
    kick(8'd5, 3'b100);
    coin_pulse("t3_c2a", 3'b010, 8'd3, 8'd2);
    coin_pulse("t3_c2b", 3'b010, 8'd1, 8'd4);
    coin_pulse("t3_c1", 3'b001, 8'd0, 8'd5);
    tick();
    chk("t3_done", 8'(bus.done), 8'd1);
    chk("t3_tot", bus.dispensed_total, 8'd5);
    tick();

    // 4: 1-hopper empty, 3 -> 2 then shortfall
    kick(8'd3, 3'b001);
    coin_pulse("t4_c2", 3'b010, 8'd1, 8'd2);
    tick();
    chk("t4_err", 8'(bus.error), 8'd1);
    chk("t4_done", 8'(bus.done), 8'd0);
    chk("t4_busy", 8'(bus.busy), 8'd0);
    chk("t4_rem", bus.remaining, 8'd1);
    chk("t4_tot", bus.dispensed_total, 8'd2);
    tick();
    chk("t4_err_clr", 8'(bus.error), 8'd0);
    chk("t4_rem_hold", bus.remaining, 8'd1);
    chk("t4_tot_hold", bus.dispensed_total, 8'd2);

    // 5: start held high throughout payout of 3
    bus.change_due   = 8'd3;
    bus.hopper_empty = 3'b000;
    bus.start        = 1'b1;
    tick();
    bus.change_due = 8'd9;
    coin_pulse("t5_c2", 3'b010, 8'd1, 8'd2);
    coin_pulse("t5_c1", 3'b001, 8'd0, 8'd3);
    tick();
    chk("t5_done", 8'(bus.done), 8'd1);
    chk("t5_tot", bus.dispensed_total, 8'd3);
    bus.start = 1'b0;
    tick();
    chk("t5_done_single", 8'(bus.done), 8'd0);
    chk("t5_idle_busy", 8'(bus.busy), 8'd0);

    // 6: async reset mid-pulse, then a normal 1-unit payout
    kick(8'd5, 3'b000);
    tick();
    chk("t6_coin_pre", 8'(bus.coin_out), 8'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_coin", 8'(bus.coin_out), 8'd0);
    chk("t6_rst_busy", 8'(bus.busy), 8'd0);
    chk("t6_rst_rem", bus.remaining, 8'd0);
    chk("t6_rst_tot", bus.dispensed_total, 8'd0);
    tick();
    rst_n = 1'b1;
    tick();
    kick(8'd1, 3'b000);
    coin_pulse("t6_c1", 3'b001, 8'd0, 8'd1);
    tick();
    chk("t6_done", 8'(bus.done), 8'd1);
    chk("t6_tot", bus.dispensed_total, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
